// File: rtl/gemmm2s_arb_pkg.sv
// rtl/gemmm2s_arb_pkg.sv - shared types and limits for the gemmm2s stream arbiter
package gemmm2s_arb_pkg;

    localparam int MAX_PORTS = 16;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry output skid buffer with registered upstream ready
module skid_buffer #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;

    // Upstream ready depends only on the skid register, so it never sees downstream ready combinationally.
    assign s_tready = !skid_valid;

    // Output register refills from the skid first; a beat arriving while the output is stalled parks in the skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata    <= '0;
            m_tvalid   <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (!m_tvalid || m_tready) begin
            if (skid_valid) begin
                m_tdata    <= skid_data;
                m_tvalid   <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                m_tvalid <= s_tvalid;
                if (s_tvalid) begin
                    m_tdata <= s_tdata;
                end
            end
        end else if (s_tvalid && s_tready) begin
            skid_data  <= s_tdata;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/gemmm2s_axis_arbiter.sv
// rtl/gemmm2s_axis_arbiter.sv - packet-locked round-robin merge of gemmm2s streams (option: GEMMM2S_ARB_TID_EN adds M_AXIS_TID)
module gemmm2s_axis_arbiter
    import gemmm2s_arb_pkg::*;
#(
    parameter int  NUM_PORTS        = 2,
    parameter int  C_AXI_DATA_WIDTH = 32,
    localparam int TID_WIDTH        = $clog2(NUM_PORTS)
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETN,
    input  logic [NUM_PORTS*C_AXI_DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [NUM_PORTS-1:0]                  S_AXIS_TLAST,
    input  logic [NUM_PORTS-1:0]                  S_AXIS_TVALID,
    output logic [NUM_PORTS-1:0]                  S_AXIS_TREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]           M_AXIS_TDATA,
    output logic                                  M_AXIS_TLAST,
    output logic                                  M_AXIS_TVALID,
    input  logic                                  M_AXIS_TREADY
`ifdef GEMMM2S_ARB_TID_EN
    ,
    output logic [TID_WIDTH-1:0]                  M_AXIS_TID
`endif
);

`ifdef GEMMM2S_ARB_TID_EN
    localparam int SKID_W = C_AXI_DATA_WIDTH + 1 + TID_WIDTH;
`else
    localparam int SKID_W = C_AXI_DATA_WIDTH + 1;
`endif

    arb_state_t                  state;
    arb_state_t                  state_next;
    logic [TID_WIDTH-1:0]        grant;
    logic [TID_WIDTH-1:0]        last_grant;
    logic [TID_WIDTH-1:0]        pick;
    logic                        pick_found;
    logic [C_AXI_DATA_WIDTH-1:0] sel_data;
    logic                        sel_last;
    logic                        sel_valid;
    logic                        buf_tvalid;
    logic                        buf_tready;
    logic                        accept_last;
    logic [SKID_W-1:0]           buf_in;
    logic [SKID_W-1:0]           buf_out;

    // Search upward from last_grant+1 with wrap; the lowest offset with a request wins.
    function automatic logic [TID_WIDTH:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                   input logic [TID_WIDTH-1:0] last);
        logic [TID_WIDTH:0] res;
        int                 idx;
        res = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_PORTS;
            if (req[idx]) begin
                res = {1'b1, idx[TID_WIDTH-1:0]};
            end
        end
        return res;
    endfunction

    assign {pick_found, pick} = rr_pick(S_AXIS_TVALID, last_grant);
    assign accept_last        = buf_tvalid && buf_tready && sel_last;

    // Route the granted source's beat toward the skid buffer.
    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == i[TID_WIDTH-1:0]) begin
                sel_data  = S_AXIS_TDATA[i*C_AXI_DATA_WIDTH +: C_AXI_DATA_WIDTH];
                sel_last  = S_AXIS_TLAST[i];
                sel_valid = S_AXIS_TVALID[i];
            end
        end
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: lock on any request, release only after the granted TLAST beat is taken.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: if (pick_found) state_next = ARB_BUSY;
            ARB_BUSY: if (accept_last) state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    // Outputs: only the granted source sees ready, and only while BUSY.
    always_comb begin
        S_AXIS_TREADY = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            S_AXIS_TREADY[i] = (state == ARB_BUSY) && (grant == i[TID_WIDTH-1:0]) && buf_tready;
        end
        buf_tvalid = (state == ARB_BUSY) && sel_valid;
    end

    // Grant captured in the arbitration cycle; last_grant advances at the end of each packet.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            grant      <= '0;
            last_grant <= TID_WIDTH'(NUM_PORTS - 1);
        end else begin
            if (state == ARB_IDLE && pick_found) begin
                grant <= pick;
            end
            if (state == ARB_BUSY && accept_last) begin
                last_grant <= grant;
            end
        end
    end

`ifdef GEMMM2S_ARB_TID_EN
    assign buf_in = {grant, sel_last, sel_data};
    assign {M_AXIS_TID, M_AXIS_TLAST, M_AXIS_TDATA} = buf_out;
`else
    assign buf_in = {sel_last, sel_data};
    assign {M_AXIS_TLAST, M_AXIS_TDATA} = buf_out;
`endif

    skid_buffer #(
        .WIDTH(SKID_W)
    ) u_skid (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .s_tdata (buf_in),
        .s_tvalid(buf_tvalid),
        .s_tready(buf_tready),
        .m_tdata (buf_out),
        .m_tvalid(M_AXIS_TVALID),
        .m_tready(M_AXIS_TREADY)
    );

endmodule

// File: tb/tb_gemmm2s_axis_arbiter.sv
// tb/tb_gemmm2s_axis_arbiter.sv - directed self-checking bench for gemmm2s_axis_arbiter
module tb_gemmm2s_axis_arbiter;

`ifdef GEMMM2S_ARB_TID_EN
    localparam int NP = 4;
`else
    localparam int NP = 2;
`endif
    localparam int W = 32;

    logic            ACLK    = 1'b0;
    logic            ARESETN = 1'b0;
    logic [NP*W-1:0] s_data  = '0;
    logic [NP-1:0]   s_last  = '0;
    logic [NP-1:0]   s_valid = '0;
    logic [NP-1:0]   s_ready;
    logic [W-1:0]    m_data;
    logic            m_last;
    logic            m_valid;
    logic            m_ready = 1'b1;
`ifdef GEMMM2S_ARB_TID_EN
    logic [$clog2(NP)-1:0] m_tid;
`endif

    gemmm2s_axis_arbiter #(
        .NUM_PORTS       (NP),
        .C_AXI_DATA_WIDTH(W)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .S_AXIS_TDATA (s_data),
        .S_AXIS_TLAST (s_last),
        .S_AXIS_TVALID(s_valid),
        .S_AXIS_TREADY(s_ready),
        .M_AXIS_TDATA (m_data),
        .M_AXIS_TLAST (m_last),
        .M_AXIS_TVALID(m_valid),
        .M_AXIS_TREADY(m_ready)
`ifdef GEMMM2S_ARB_TID_EN
        ,
        .M_AXIS_TID   (m_tid)
`endif
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        mr;
        int          sr;
        logic        mv;
        logic [31:0] md;
        logic        ml;
    } vec_t;

    vec_t        tbl [7];
    logic [32:0] srcq [NP][$];
    logic [NP-1:0] en = '0;
    logic        auto_drv = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          acc_cyc [$];
    int          acc_src [$];
    logic        acc_last [$];
    logic [31:0] out_d [$];
    logic        out_l [$];
    int          out_t [$];
    logic [31:0] exp_d [$];
    logic        exp_l [$];
    logic        prev_hold = 1'b0;
    logic [31:0] prev_d;
    logic        prev_l;
    logic [NP-1:0] sr_smp;
    logic        mv_smp;
    logic [31:0] md_smp;
    logic        ml_smp;
    logic [NP-1:0] exp_sr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    function automatic logic pending();
        logic p;
        p = m_valid;
        for (int i = 0; i < NP; i++) if (en[i] && srcq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    function automatic int count_acc(input int s);
        int n;
        n = 0;
        foreach (acc_src[j]) if (acc_src[j] == s) n++;
        return n;
    endfunction

    task automatic push_pkt(input int src, input int base, input int len);
        for (int b = 0; b < len; b++) srcq[src].push_back({(b == len - 1), 32'(base + b)});
    endtask

    task automatic expect_pkt(input int base, input int len);
        for (int b = 0; b < len; b++) begin
            exp_d.push_back(32'(base + b));
            exp_l.push_back(b == len - 1);
        end
    endtask

    // One clock: drive, sample at the falling edge, log handshakes, return just after the rising edge.
    task automatic cycle();
        if (auto_drv) begin
            for (int i = 0; i < NP; i++) begin
                if (en[i] && srcq[i].size() > 0) begin
                    s_valid[i]       = 1'b1;
                    s_data[i*W +: W] = srcq[i][0][31:0];
                    s_last[i]        = srcq[i][0][32];
                end else begin
                    s_valid[i] = 1'b0;
                    s_last[i]  = 1'b0;
                end
            end
        end
        @(negedge ACLK);
        sr_smp = s_ready;
        mv_smp = m_valid;
        md_smp = m_data;
        ml_smp = m_last;
        chk("tready_onehot", 64'($countones(s_ready) <= 1), 64'd1);
        if (prev_hold) begin
            chk("hold_valid", m_valid, 1'b1);
            chk("hold_data", m_data, prev_d);
            chk("hold_last", m_last, prev_l);
        end
        for (int i = 0; i < NP; i++) begin
            if (s_valid[i] && s_ready[i]) begin
                acc_cyc.push_back(cyc);
                acc_src.push_back(i);
                acc_last.push_back(s_last[i]);
                if (auto_drv) void'(srcq[i].pop_front());
            end
        end
        if (m_valid && m_ready) begin
            out_d.push_back(m_data);
            out_l.push_back(m_last);
`ifdef GEMMM2S_ARB_TID_EN
            out_t.push_back(int'(m_tid));
`else
            out_t.push_back(0);
`endif
        end
        prev_hold = m_valid && !m_ready;
        prev_d    = m_data;
        prev_l    = m_last;
        cyc++;
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESETN   = 1'b0;
        s_valid   = '0;
        s_last    = '0;
        s_data    = '0;
        en        = '0;
        m_ready   = 1'b1;
        prev_hold = 1'b0;
        for (int i = 0; i < NP; i++) srcq[i].delete();
        acc_cyc.delete(); acc_src.delete(); acc_last.delete();
        out_d.delete(); out_l.delete(); out_t.delete();
        exp_d.delete(); exp_l.delete();
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("reset_tready", s_ready, '0);
        chk("reset_mvalid", m_valid, 1'b0);
        chk("reset_mdata", m_data, 32'd0);
        chk("reset_mlast", m_last, 1'b0);
`ifdef GEMMM2S_ARB_TID_EN
        chk("reset_tid", m_tid, '0);
`endif
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        cyc     = 0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (pending() && k < 300) begin
            cycle();
            k++;
        end
        chk({name, "_timeout"}, pending(), 1'b0);
        repeat (2) cycle();
    endtask

    task automatic compare_out(input string name);
        int n;
        chk({name, "_count"}, out_d.size(), exp_d.size());
        n = (out_d.size() < exp_d.size()) ? out_d.size() : exp_d.size();
        for (int j = 0; j < n; j++) begin
            chk($sformatf("%s_data%0d", name, j), out_d[j], exp_d[j]);
            chk($sformatf("%s_last%0d", name, j), out_l[j], exp_l[j]);
        end
    endtask

    initial begin
        //            v     data      last  mr    sr  mv    mdata     mlast
        tbl[0] = '{1'b1, 32'hA0, 1'b0, 1'b1, 0, 1'b0, 32'h00, 1'b0};
        tbl[1] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1, 1'b0, 32'h00, 1'b0};
        tbl[2] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1, 1'b1, 32'hA0, 1'b0};
        tbl[3] = '{1'b1, 32'hA2, 1'b0, 1'b1, 1, 1'b1, 32'hA1, 1'b0};
        tbl[4] = '{1'b1, 32'hA3, 1'b1, 1'b1, 1, 1'b1, 32'hA2, 1'b0};
        tbl[5] = '{1'b0, 32'h00, 1'b0, 1'b1, 0, 1'b1, 32'hA3, 1'b1};
        tbl[6] = '{1'b0, 32'h00, 1'b0, 1'b1, 0, 1'b0, 32'h00, 1'b0};

        // Single source, cycle-exact vectors.
        do_reset();
        auto_drv = 1'b0;
        for (int k = 0; k < 7; k++) begin
            s_valid          = '0;
            s_last           = '0;
            s_data           = '0;
            s_valid[0]       = tbl[k].v;
            s_last[0]        = tbl[k].l;
            s_data[W-1:0]    = tbl[k].d;
            m_ready          = tbl[k].mr;
            cycle();
            exp_sr = tbl[k].sr[NP-1:0];
            chk($sformatf("tbl%0d_tready", k), sr_smp, exp_sr);
            chk($sformatf("tbl%0d_mvalid", k), mv_smp, tbl[k].mv);
            if (tbl[k].mv) begin
                chk($sformatf("tbl%0d_mdata", k), md_smp, tbl[k].md);
                chk($sformatf("tbl%0d_mlast", k), ml_smp, tbl[k].ml);
            end
        end

        // Contention: two packets per source, strict alternation and one-cycle gaps.
        do_reset();
        auto_drv = 1'b1;
        push_pkt(0, 'h100, 3); push_pkt(0, 'h103, 3);
        push_pkt(1, 'h200, 3); push_pkt(1, 'h203, 3);
        en[0] = 1'b1; en[1] = 1'b1;
        drain("cont");
        expect_pkt('h100, 3); expect_pkt('h200, 3); expect_pkt('h103, 3); expect_pkt('h203, 3);
        compare_out("cont");
        for (int j = 1; j < acc_cyc.size(); j++)
            chk($sformatf("cont_gap%0d", j), acc_cyc[j] - acc_cyc[j-1], acc_last[j-1] ? 2 : 1);

        // Mid-packet stall keeps the grant on source 1.
        do_reset();
        push_pkt(1, 'h500, 4);
        en[1] = 1'b1;
        begin
            int k;
            k = 0;
            while (count_acc(1) < 2 && k < 50) begin
                cycle();
                k++;
            end
        end
        chk("stall_reach", count_acc(1), 2);
        en[1] = 1'b0;
        push_pkt(0, 'h600, 2);
        en[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            exp_sr    = '0;
            exp_sr[1] = 1'b1;
            chk($sformatf("stall_grant%0d", k), sr_smp, exp_sr);
        end
        en[1] = 1'b1;
        drain("stall");
        expect_pkt('h500, 4); expect_pkt('h600, 2);
        compare_out("stall");

        // Output backpressure during a 6-beat packet.
        do_reset();
        push_pkt(0, 'hE0, 6);
        en[0] = 1'b1;
        for (int k = 0; k < 100 && pending(); k++) begin
            m_ready = (k == 4 || k == 5) ? 1'b0 : 1'b1;
            cycle();
            if (k == 5) chk("bp_upstream_stall", sr_smp, '0);
        end
        m_ready = 1'b1;
        drain("bp");
        expect_pkt('hE0, 6);
        compare_out("bp");

        // Reset in the middle of a packet.
        do_reset();
        push_pkt(0, 'hF0, 4);
        en[0] = 1'b1;
        begin
            int k;
            k = 0;
            while (count_acc(0) < 2 && k < 50) begin
                cycle();
                k++;
            end
        end
        chk("rst_reach", count_acc(0), 2);
        ARESETN = 1'b0;
        #1;
        chk("rst_mvalid_now", m_valid, 1'b0);
        chk("rst_tready_now", s_ready, '0);
        do_reset();
        push_pkt(1, 'h300, 1);
        push_pkt(0, 'h400, 2);
        en[0] = 1'b1; en[1] = 1'b1;
        drain("rst");
        expect_pkt('h400, 2); expect_pkt('h300, 1);
        compare_out("rst");

`ifdef GEMMM2S_ARB_TID_EN
        // Source index travels with each beat.
        do_reset();
        push_pkt(2, 'h22, 1);
        push_pkt(3, 'h33, 1);
        en = '1;
        drain("tid");
        expect_pkt('h22, 1); expect_pkt('h33, 1);
        compare_out("tid");
        chk("tid_count", out_t.size(), 2);
        if (out_t.size() >= 2) begin
            chk("tid_first", out_t[0], 2);
            chk("tid_second", out_t[1], 3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
